// File: rtl/program_loader_if.sv
// Byte-stream in / program-memory write out bundle for the program loader.
// Latency: none (wires only).
// Backpressure: byte_valid/byte_ready handshake; the memory side has no stall.
//
// Signals:
//   start, base_addr, word_count    : load command (start is a 1-cycle pulse)
//   byte_valid, byte_data, byte_ready : little-endian byte stream
//   mem_we, mem_addr, mem_wdata       : one-cycle program-memory write
//   busy, done, checksum              : load status
// slave  = loader side, master = command/stream source and memory sink.
interface program_loader_if #(
  parameter int INSTR_ADDR_WIDTH = 20,
  parameter int STEP             = 4
);
  logic                          start;
  logic [INSTR_ADDR_WIDTH-1:0]   base_addr;
  logic [INSTR_ADDR_WIDTH:0]     word_count;
  logic                          byte_valid;
  logic [7:0]                    byte_data;
  logic                          byte_ready;
  logic                          mem_we;
  logic [INSTR_ADDR_WIDTH-1:0]   mem_addr;
  logic [STEP*8-1:0]             mem_wdata;
  logic                          busy;
  logic                          done;
  logic [7:0]                    checksum;

  modport slave (
    input  start, base_addr, word_count, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum
  );

  modport master (
    output start, base_addr, word_count, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, checksum
  );
endinterface

// File: rtl/program_loader.sv
// Packs a little-endian byte stream into STEP-byte words and writes them to
// consecutive program-memory addresses from base_addr.
// Latency: last byte of a word accepted in cycle N -> mem_we in cycle N+1;
// STEP+1 cycles per word sustained.
// Backpressure: byte_ready is high only while collecting bytes (RECV).
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : program_loader_if.slave (command, byte stream, memory write, status)
module program_loader #(
  parameter int INSTR_ADDR_WIDTH = 20,
  parameter int STEP             = 4
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.slave  bus
);
  localparam int W    = INSTR_ADDR_WIDTH;
  localparam int IDXW = (STEP > 1) ? $clog2(STEP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      base_q, base_d;
  logic [W:0]        count_q, count_d;
  logic [W:0]        written_q, written_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [STEP*8-1:0] word_q, word_d;
  logic [W-1:0]      addr_q, addr_d;
  logic [STEP*8-1:0] wdata_q, wdata_d;
  logic [7:0]        checksum_q, checksum_d;

  logic              accept;
  logic              last_byte;
  logic [STEP*8-1:0] word_next;
  logic [W:0]        written_inc;

  assign accept      = (state_q == S_RECV) && bus.byte_valid;
  assign last_byte   = (idx_q == IDXW'(STEP - 1));
  assign written_inc = written_q + (W+1)'(1);

  // Current word with the incoming byte dropped into lane idx_q.
  always_comb begin
    word_next = word_q;
    for (int k = 0; k < STEP; k++) begin
      if (idx_q == IDXW'(k)) begin
        word_next[k*8 +: 8] = bus.byte_data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    written_d  = written_q;
    idx_d      = idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    checksum_d = checksum_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d     = bus.base_addr;
          count_d    = bus.word_count;
          written_d  = '0;
          idx_d      = '0;
          checksum_d = '0;
          state_d    = (bus.word_count == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (accept) begin
          word_d     = word_next;
          checksum_d = checksum_q + bus.byte_data;
          if (last_byte) begin
            idx_d = '0;
            // Address and data are registered here so they are valid during
            // WRITE and then hold until the next write.
            addr_d  = base_q + written_q[W-1:0];
            wdata_d = word_next;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      S_WRITE: begin
        written_d = written_inc;
        state_d   = (written_inc == count_q) ? S_DONE : S_RECV;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      written_q  <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      written_q  <= written_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      checksum_q <= checksum_d;
    end
  end

  assign bus.byte_ready = (state_q == S_RECV);
  assign bus.mem_we     = (state_q == S_WRITE);
  assign bus.busy       = (state_q == S_RECV) || (state_q == S_WRITE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.checksum   = checksum_q;
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a queue-based reference model.
// Latency: expected write cycle derived from the byte acceptance cycle.
// Backpressure: byte_valid driven randomly, including outside RECV.
module tb_program_loader;
  localparam int W    = 20;
  localparam int STEP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_loader_if #(.INSTR_ADDR_WIDTH(W), .STEP(STEP)) pif();

  program_loader #(.INSTR_ADDR_WIDTH(W), .STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state: bytes to send and the writes they must produce.
  logic [7:0]        stim[$];
  logic [W-1:0]      exp_addr_q[$];
  logic [STEP*8-1:0] exp_data_q[$];
  int                exp_we_cyc_q[$];

  int cyc         = 0;
  int done_cnt    = 0;
  int done_cyc    = -1;
  int last_we_cyc = -1;
  int we_cnt      = 0;
  bit busy_seen   = 1'b0;

  // Output monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (pif.mem_we) begin
      we_cnt++;
      last_we_cyc = cyc;
      check_eq("busy_in_write", pif.busy, 1);
      if (exp_addr_q.size() == 0) begin
        check_eq("unexpected_write", pif.mem_we, 0);
      end else begin
        check_eq("mem_addr", pif.mem_addr, exp_addr_q.pop_front());
        check_eq("mem_wdata", pif.mem_wdata, exp_data_q.pop_front());
        if (exp_we_cyc_q.size() != 0)
          check_eq("write_latency", cyc, exp_we_cyc_q.pop_front());
        else
          check_eq("write_before_last_byte", pif.mem_we, 0);
      end
    end
    if (pif.busy) busy_seen = 1'b1;
    if (pif.done) begin
      done_cnt++;
      done_cyc = cyc;
      check_eq("busy_in_done", pif.busy, 0);
    end
  end

  task automatic fill_random(input int nbytes);
    stim.delete();
    for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_byte_ready"}, pif.byte_ready, 0);
    check_eq({tag, "_mem_we"},     pif.mem_we, 0);
    check_eq({tag, "_mem_addr"},   pif.mem_addr, 0);
    check_eq({tag, "_mem_wdata"},  pif.mem_wdata, 0);
    check_eq({tag, "_busy"},       pif.busy, 0);
    check_eq({tag, "_done"},       pif.done, 0);
    check_eq({tag, "_checksum"},   pif.checksum, 0);
  endtask

  // One load: builds the expected write list from stim, drives the command and
  // the byte stream, then checks the outcome. abort_at >= 0 stops feeding once
  // that many bytes are accepted and returns without the end-of-load checks.
  task automatic run_load(input logic [W-1:0] base, input int count, input bit gap,
                          input bit restart_mid, input int abort_at);
    int idx    = 0;
    int nbytes = count * STEP;
    int t      = 0;
    int d0, w0, start_cyc;
    logic [7:0]        ck = 8'h00;
    logic [STEP*8-1:0] word;

    for (int w = 0; w < count; w++) begin
      word = '0;
      for (int k = 0; k < STEP; k++) begin
        word = word | ((STEP*8)'(stim[w*STEP + k]) << (8*k));
        ck   = ck + stim[w*STEP + k];
      end
      exp_addr_q.push_back(base + W'(w));
      exp_data_q.push_back(word);
    end
    d0 = done_cnt;
    w0 = we_cnt;
    busy_seen = 1'b0;

    @(negedge clk);
    pif.start      = 1'b1;
    pif.base_addr  = base;
    pif.word_count = (W+1)'(count);
    start_cyc      = cyc + 1;

    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
      pif.start = 1'b0;
      if (restart_mid && idx == STEP + 1) begin
        pif.start      = 1'b1;
        pif.base_addr  = ~base;
        pif.word_count = (W+1)'(count + 3);
      end
      if (abort_at >= 0 && idx == abort_at) break;
      if (pif.byte_ready) begin
        pif.byte_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
        pif.byte_data  = (idx < nbytes) ? stim[idx] : 8'($urandom);
        if (pif.byte_valid && idx < nbytes) begin
          if (idx % STEP == STEP - 1) exp_we_cyc_q.push_back(cyc + 1);
          idx++;
        end
      end else begin
        // Junk traffic while the loader is not ready must be ignored.
        pif.byte_valid = 1'($urandom_range(0, 1));
        pif.byte_data  = 8'($urandom);
      end
    end
    pif.byte_valid = 1'b0;
    pif.start      = 1'b0;
    if (abort_at >= 0) return;

    repeat (3) @(negedge clk);
    check_eq("done_pulses", done_cnt - d0, 1);
    check_eq("write_count", we_cnt - w0, count);
    check_eq("checksum", pif.checksum, ck);
    check_eq("pending_writes", exp_addr_q.size(), 0);
    if (count == 0) begin
      check_eq("empty_busy_seen", busy_seen, 0);
      check_eq("empty_done_cycle", done_cyc, start_cyc);
    end else begin
      check_eq("done_after_last_write", done_cyc, last_we_cyc + 1);
    end
  endtask

  int w_before;

  initial begin
    rst            = 1'b1;
    pif.start      = 1'b0;
    pif.base_addr  = '0;
    pif.word_count = '0;
    pif.byte_valid = 1'b0;
    pif.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T1: two known instructions, continuous stream.
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(20'h00010, 2, 1'b0, 1'b0, -1);
    check_eq("t1_checksum", pif.checksum, 8'hB6);

    // T2: zero-length load.
    stim.delete();
    run_load(20'h00123, 0, 1'b0, 1'b0, -1);

    // T3: address wrap at the top of program memory.
    fill_random(2 * STEP);
    run_load({W{1'b1}}, 2, 1'b1, 1'b0, -1);

    // T4: T1 bytes with gaps and junk outside RECV.
    stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(20'h00010, 2, 1'b1, 1'b0, -1);

    // T5: reset after two bytes of word 0, then a clean reload.
    fill_random(2 * STEP);
    run_load(20'h00400, 2, 1'b0, 1'b0, 2);
    check_eq("t5_pre_reset_busy", pif.busy, 1);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_we_cyc_q.delete();
    w_before = we_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("t5_no_write_on_abort", we_cnt - w_before, 0);
    fill_random(2 * STEP);
    run_load(20'h00400, 2, 1'b1, 1'b0, -1);

    // T6: start pulses while busy are ignored.
    fill_random(3 * STEP);
    run_load(20'h0ABCD, 3, 1'b1, 1'b1, -1);

    // Random loads.
    for (int r = 0; r < 6; r++) begin
      int cnt;
      cnt = $urandom_range(1, 5);
      fill_random(cnt * STEP);
      run_load(W'($urandom), cnt, 1'b1, 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
